// File: rtl/alu_pkg.sv
// Shared ALU-side types for the HI/LO multiply sequencer.
//   mult_op_e    : request opcode encodings carried on req_op
//   mult_state_e : sequencer states
//   XLEN_DEF     : default operand/register width
package alu_pkg;
   localparam int XLEN_DEF = 32;

   typedef enum logic [2:0] {
      OP_MULT = 3'd0,
      OP_MTHI = 3'd1,
      OP_MTLO = 3'd2,
      OP_MFHI = 3'd3,
      OP_MFLO = 3'd4,
      OP_MADD = 3'd5,
      OP_RSV6 = 3'd6,
      OP_RSV7 = 3'd7
   } mult_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      WAIT   = 2'd2,
      COMMIT = 2'd3
   } mult_state_e;
endpackage

// File: rtl/mult_hilo_regs.sv
// HI/LO register pair with move-to write port, read mux and commit path.
// Optional feature macro: MULT_HILO_MADD_EN adds a 2*XLEN accumulate adder so
// a commit with accum=1 writes {HI,LO}+prod (wrapping); otherwise the commit
// is a plain copy and accum is ignored.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_hi, wr_lo    move-to strobes, data on wr_data
//   commit, accum   write product (or accumulate) into {HI,LO}
//   prod            registered product from the sequencer
//   rd_hi           read select: 1=HI, 0=LO
//   rd_data         selected register value
module mult_hilo_regs
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_hi,
   input  logic              wr_lo,
   input  logic [XLEN-1:0]   wr_data,
   input  logic              commit,
   input  logic              accum,
   input  logic [2*XLEN-1:0] prod,
   input  logic              rd_hi,
   output logic [XLEN-1:0]   rd_data
);
   logic [XLEN-1:0]   hi, lo;
   logic [2*XLEN-1:0] nxt_hilo;

`ifdef MULT_HILO_MADD_EN
   assign nxt_hilo = accum ? ({hi, lo} + prod) : prod;
`else
   logic unused_accum;
   assign unused_accum = accum;
   assign nxt_hilo     = prod;
`endif

   // Commit and move-to can never coincide: move-to only happens in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         {hi, lo} <= nxt_hilo;
      end else begin
         if (wr_hi) hi <= wr_data;
         if (wr_lo) lo <= wr_data;
      end
   end

   assign rd_data = rd_hi ? hi : lo;
endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequencer between the ALU and an iterative signed multiplier core.
// Accepts MULT/MADD/MTHI/MTLO/MFHI/MFLO, pulses the core start, waits for done
// with a timeout, commits the product into HI:LO and stalls requests while busy.
// Optional feature macro: MULT_HILO_MADD_EN enables op 5 (MADD); without it
// op 5 is discarded like the reserved opcodes.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/ready/op/a/b           request handshake and operands
//   resp_valid, resp_data            one-cycle read response
//   busy, err                        multiply in flight, sticky timeout
//   mul_a, mul_b, mul_start          to core
//   mul_done, mul_product            from core
module mult_hilo_ctrl
   import alu_pkg::*;
#(
   parameter int XLEN        = XLEN_DEF,
   parameter int MUL_TIMEOUT = 64,
   parameter int TO_W        = $clog2(MUL_TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [XLEN-1:0]   req_a,
   input  logic [XLEN-1:0]   req_b,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_data,
   output logic              busy,
   output logic              err,
   output logic [XLEN-1:0]   mul_a,
   output logic [XLEN-1:0]   mul_b,
   output logic              mul_start,
   input  logic              mul_done,
   input  logic [2*XLEN-1:0] mul_product
);
   localparam logic [TO_W-1:0] CNT_LAST = TO_W'(MUL_TIMEOUT - 1);

   mult_state_e       state, nxt;
   mult_op_e          op;
   logic [TO_W-1:0]   cnt;
   logic [2*XLEN-1:0] prod_q;
   logic              madd_q;
   logic              acc, is_mult, is_madd, is_mf;
   logic [XLEN-1:0]   rd_data;

   assign op        = mult_op_e'(req_op);
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign acc       = req_valid & req_ready;
   assign is_mult   = acc & (op == OP_MULT);
   assign is_mf     = acc & ((op == OP_MFHI) | (op == OP_MFLO));
`ifdef MULT_HILO_MADD_EN
   assign is_madd   = acc & (op == OP_MADD);
`else
   assign is_madd   = 1'b0;
`endif

   always_comb begin
      nxt       = state;
      mul_start = 1'b0;
      case (state)
         IDLE:   if (is_mult | is_madd) nxt = START;
         START: begin
            mul_start = 1'b1;
            nxt       = WAIT;
         end
         // done is only looked at here, so a level left over from a previous
         // op (or arriving after a reset) cannot be mistaken for completion.
         WAIT: begin
            if (mul_done)             nxt = COMMIT;
            else if (cnt == CNT_LAST) nxt = IDLE;
         end
         COMMIT: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         mul_a      <= '0;
         mul_b      <= '0;
         madd_q     <= 1'b0;
         prod_q     <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         err        <= 1'b0;
      end else begin
         state      <= nxt;
         resp_valid <= is_mf;
         if (is_mf) resp_data <= rd_data;
         // Operands only change on accept, which keeps them stable for the core.
         if (is_mult | is_madd) begin
            mul_a  <= req_a;
            mul_b  <= req_b;
            madd_q <= is_madd;
         end
         case (state)
            START: cnt <= '0;
            WAIT: begin
               if (mul_done) begin
                  prod_q <= mul_product;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST) err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   mult_hilo_regs #(.XLEN(XLEN)) u_regs (
      .clk     (clk),
      .rst     (rst),
      .wr_hi   (acc & (op == OP_MTHI)),
      .wr_lo   (acc & (op == OP_MTLO)),
      .wr_data (req_a),
      .commit  (state == COMMIT),
      .accum   (madd_q),
      .prod    (prod_q),
      .rd_hi   (op == OP_MFHI),
      .rd_data (rd_data)
   );
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Self-checking bench for mult_hilo_ctrl with a behavioural multiplier core
// (programmable latency, or a stub that never finishes) and a HI/LO model.
module tb_mult_hilo_ctrl;
   import alu_pkg::*;
   localparam int XLEN = 32;
   localparam int TMO  = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [2:0]        req_op = 3'd0;
   logic [XLEN-1:0]   req_a = '0, req_b = '0;
   logic              resp_valid;
   logic [XLEN-1:0]   resp_data;
   logic              busy, err;
   logic [XLEN-1:0]   mul_a, mul_b;
   logic              mul_start;
   logic              mul_done = 1'b0;
   logic [2*XLEN-1:0] mul_product = '0;

   mult_hilo_ctrl #(.XLEN(XLEN), .MUL_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .busy(busy), .err(err),
      .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
      .mul_done(mul_done), .mul_product(mul_product)
   );

   always #5 clk = ~clk;

`ifdef MULT_HILO_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   int n_chk = 0, n_fail = 0;
   int core_lat = 3;
   bit stub = 1'b0;
   int core_cnt = 0;
   logic both_seen = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0;

   function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] x, y;
      x = {{32{a[31]}}, a};
      y = {{32{b[31]}}, b};
      return x * y;
   endfunction

   // Behavioural core: done drops on start, rises core_lat cycles later, holds.
   always @(posedge clk) begin
      if (mul_start) begin
         mul_done <= 1'b0;
         core_cnt <= core_lat;
      end else if (core_cnt != 0) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1 && !stub) begin
            mul_done    <= 1'b1;
            mul_product <= smul(mul_a, mul_b);
         end
      end
   end

   always @(negedge clk) if (mul_start && resp_valid) both_seen <= 1'b1;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      stalls = 0;
      while (!req_ready && stalls < 300) begin
         @(negedge clk);
         stalls++;
      end
      if (!req_ready) chk("accept_timeout", 0, 1);
      else @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(output int bc, output int sc, output int wc);
      bc = 0; sc = 0; wc = 0;
      while (busy && bc < 300) begin
         bc++;
         if (mul_start) sc++; else wc++;
         @(negedge clk);
      end
      if (busy) chk("idle_timeout", 0, 1);
   endtask

   task automatic rd(input logic [2:0] op, output logic [31:0] d);
      int s;
      issue(op, 32'h0, 32'h0, s);
      chk("rd_vld", resp_valid, 1);
      d = resp_data;
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int s, bc, sc, wc;
      logic [63:0] acc;
      issue(op, a, b, s);
      if (op == OP_MTHI) begin
         m_hi = a; chk("mthi_novld", resp_valid, 0);
      end else if (op == OP_MTLO) begin
         m_lo = a; chk("mtlo_novld", resp_valid, 0);
      end else if (op == OP_MFHI) begin
         chk("mfhi_vld", resp_valid, 1); chk("mfhi", resp_data, m_hi);
      end else if (op == OP_MFLO) begin
         chk("mflo_vld", resp_valid, 1); chk("mflo", resp_data, m_lo);
      end else if (op == OP_MULT || (op == OP_MADD && MADD_EN)) begin
         acc = (op == OP_MADD) ? {m_hi, m_lo} : 64'd0;
         {m_hi, m_lo} = acc + smul(a, b);
         chk("mul_novld", resp_valid, 0);
         wait_idle(bc, sc, wc);
         chk("mul_busy_cyc", bc, core_lat + 3);
         chk("mul_start_cyc", sc, 1);
      end else begin
         chk("rsv_novld", resp_valid, 0);
         chk("rsv_idle", busy, 0);
      end
   endtask

   initial begin
      int s, bc, sc, wc;
      logic [31:0] d, a, b;
      logic [31:0] corner [5];
      logic [2:0] op;
      logic exp_err;
      corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFFFFFF;
      corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_start", mul_start, 0);
      chk("rst_rvld", resp_valid, 0);
      chk("rst_rdata", resp_data, 0);
      chk("rst_mula", mul_a, 0);
      chk("rst_mulb", mul_b, 0);
      chk("rst_ready", req_ready, 1);
      rd(OP_MFHI, d); chk("rst_hi", d, 0);
      rd(OP_MFLO, d); chk("rst_lo", d, 0);

      // 7 * -3
      core_lat = 3;
      do_op(OP_MULT, 32'd7, 32'hFFFFFFFD);
      rd(OP_MFLO, d); chk("t1_lo", d, 32'hFFFFFFEB);
      rd(OP_MFHI, d); chk("t1_hi", d, 32'hFFFFFFFF);

      // most-negative squared
      core_lat = 5;
      do_op(OP_MULT, 32'h80000000, 32'h80000000);
      rd(OP_MFHI, d); chk("t2_hi", d, 32'h40000000);
      rd(OP_MFLO, d); chk("t2_lo", d, 32'h00000000);

      // MFHI right behind a MULT stalls until IDLE and sees the new HI
      core_lat = 2;
      issue(OP_MULT, 32'hFFFF0000, 32'h00000010, s);
      {m_hi, m_lo} = smul(32'hFFFF0000, 32'h00000010);
      chk("t3_ready_low", req_ready, 0);
      issue(OP_MFHI, 32'h0, 32'h0, s);
      chk("t3_stalls", s, core_lat + 3);
      chk("t3_vld", resp_valid, 1);
      chk("t3_hi", resp_data, 32'hFFFFFFFF);

      // Core never completes: timeout after TMO WAIT cycles, HI/LO kept
      stub = 1'b1;
      issue(OP_MULT, 32'd9, 32'd9, s);
      wait_idle(bc, sc, wc);
      chk("t4_wait_cyc", wc, TMO);
      chk("t4_err", err, 1);
      chk("t4_ready", req_ready, 1);
      rd(OP_MFHI, d); chk("t4_hi", d, m_hi);
      rd(OP_MFLO, d); chk("t4_lo", d, m_lo);
      stub = 1'b0;

      // Reset in the middle of WAIT; late done must be ignored
      core_lat = 10;
      issue(OP_MULT, 32'd3, 32'd4, s);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_hi = '0; m_lo = '0;
      chk("t5_busy", busy, 0);
      chk("t5_start", mul_start, 0);
      chk("t5_err", err, 0);
      chk("t5_mula", mul_a, 0);
      repeat (15) @(negedge clk);
      chk("t5_late_done_idle", busy, 0);
      rd(OP_MFHI, d); chk("t5_hi", d, 0);
      rd(OP_MFLO, d); chk("t5_lo", d, 0);
      core_lat = 4;
      do_op(OP_MULT, 32'd5, 32'd6);
      rd(OP_MFLO, d); chk("t5_lo30", d, 32'd30);

`ifdef MULT_HILO_MADD_EN
      do_op(OP_MTLO, 32'h10, 32'h0);
      do_op(OP_MTHI, 32'h0, 32'h0);
      do_op(OP_MADD, 32'd2, 32'd3);
      rd(OP_MFLO, d); chk("t6_lo", d, 32'h16);
      rd(OP_MFHI, d); chk("t6_hi", d, 32'h0);
      do_op(OP_MTLO, 32'hFFFFFFFF, 32'h0);
      do_op(OP_MADD, 32'd1, 32'd1);
      rd(OP_MFLO, d); chk("t6_wrap_lo", d, 32'h0);
      rd(OP_MFHI, d); chk("t6_wrap_hi", d, 32'h1);
`else
      do_op(OP_MTLO, 32'h10, 32'h0);
      do_op(OP_MADD, 32'd2, 32'd3);
      rd(OP_MFLO, d); chk("t6_madd_off_lo", d, 32'h10);
`endif

      // Random mix against the model
      exp_err = err;
      for (int i = 0; i < 300; i++) begin
         op = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         core_lat = $urandom_range(1, 6);
         do_op(op, a, b);
         if (i % 25 == 0) chk("rnd_err", err, exp_err);
      end
      rd(OP_MFHI, d); chk("rnd_final_hi", d, m_hi);
      rd(OP_MFLO, d); chk("rnd_final_lo", d, m_lo);

      chk("start_resp_excl", both_seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
